// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO in front of the UART transmitter. System-side logic pushes bytes
//   into a DEPTH-entry circular buffer; a small FSM hands them one at a time to
//   the transmitter through the dintx/newd/donetx handshake. After each
//   donetx, GAP_CYCLES idle cycles are inserted before the next newd.
//
//   Optional feature macro: UART_TXF_OVF_EN adds a sticky overflow flag (ovf).
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous reset, active low
//   wr_en    in   push request
//   wr_data  in   byte to push
//   full     out  FIFO holds DEPTH bytes
//   empty    out  FIFO holds no bytes
//   count    out  current occupancy
//   dintx    out  byte presented to the transmitter
//   newd     out  one-cycle start pulse to the transmitter
//   donetx   in   transmitter frame-complete indication
//   busy     out  FSM is not idle
//   ovf      out  sticky overflow flag (UART_TXF_OVF_EN only)

module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             dintx,
    output logic                   newd,
    input  logic                   donetx,
    output logic                   busy
`ifdef UART_TXF_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [7:0]    mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    state_q,  state_d;
    logic [GW-1:0] gap_q,    gap_d;
    logic [7:0]    dintx_q,  dintx_d;
    logic          newd_q,   newd_d;

    logic          full_w;
    logic          empty_w;
    logic          push;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Pre-edge full decides acceptance, so a pop on the same edge never frees a slot.
    assign push = wr_en && !full_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        state_d  = state_q;
        gap_d    = gap_q;
        dintx_d  = dintx_q;
        newd_d   = newd_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!empty_w) begin
                    state_d  = ST_SEND;
                    dintx_d  = mem[rd_ptr_q[AW-1:0]];
                    newd_d   = 1'b1;
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end
            ST_SEND: begin
                newd_d  = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (donetx) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GW'(GAP_CYCLES);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                newd_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= ST_IDLE;
            gap_q    <= '0;
            dintx_q  <= '0;
            newd_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            gap_q    <= gap_d;
            dintx_q  <= dintx_d;
            newd_q   <= newd_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

`ifdef UART_TXF_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (wr_en && full_w) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

    assign full  = full_w;
    assign empty = empty_w;
    assign count = wr_ptr_q - rd_ptr_q;
    assign dintx = dintx_q;
    assign newd  = newd_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int GAP   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = CW + 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [7:0]    dintx;
    logic          newd;
    logic          donetx;
    logic          busy;
`ifdef UART_TXF_OVF_EN
    logic          ovf;
`endif

    int vectors    = 0;
    int miscompares = 0;

    uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .dintx   (dintx),
        .newd    (newd),
        .donetx  (donetx),
        .busy    (busy)
`ifdef UART_TXF_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus frame timestamps. A frame may start at
    // any edge >= m_ready while no frame is outstanding; donetx counts only from
    // the second edge after a start; the next start is allowed GAP+1 edges
    // after the accepted donetx.
    logic [7:0] m_q[$];
    int         cyc;
    int         m_start;
    int         m_ready;
    bit         m_waiting;
    logic [7:0] m_dintx;
    bit         m_newd;
    bit         m_ovf;

    function automatic void model_reset();
        m_q.delete();
        m_start   = -100;
        m_ready   = 0;
        m_waiting = 0;
        m_dintx   = 8'h00;
        m_newd    = 0;
        m_ovf     = 0;
    endfunction

    function automatic void model_edge(input bit w, input logic [7:0] d, input bit dn);
        bit pre_full;
        bit pre_empty;
        cyc++;
        pre_full  = (m_q.size() == DEPTH);
        pre_empty = (m_q.size() == 0);
        m_newd = 0;
        if (m_waiting) begin
            if (dn && cyc >= m_start + 2) begin
                m_waiting = 0;
                m_ready   = cyc + GAP + 1;
            end
        end else if (cyc >= m_ready && !pre_empty) begin
            m_dintx   = m_q.pop_front();
            m_newd    = 1;
            m_waiting = 1;
            m_start   = cyc;
        end
        if (w) begin
            if (!pre_full) m_q.push_back(d);
            else           m_ovf = 1;
        end
    endfunction

    function automatic bit m_busy();
        return m_waiting || (cyc < m_ready - 1);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic ov;
        ov = 1'b0;
`ifdef UART_TXF_OVF_EN
        ov = m_ovf;
`endif
        return {ov, m_q.size() == DEPTH, m_q.size() == 0, CW'(m_q.size()),
                m_dintx, m_newd, m_busy()};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        logic ov;
        ov = 1'b0;
`ifdef UART_TXF_OVF_EN
        ov = ovf;
`endif
        return {ov, full, empty, count, dintx, newd, busy};
    endfunction

    // Drive inputs, take one edge, advance the model, then settle 1 time unit.
    task automatic tick(input bit w, input logic [7:0] d, input bit dn);
        wr_en   = w;
        wr_data = d;
        donetx  = dn;
        @(posedge clk);
        if (!rst) begin
            cyc++;
            model_reset();
        end else begin
            model_edge(w, d, dn);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 0; wr_data = 0; donetx = 0;
        cyc = 0;
        model_reset();
        #1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_async got=%h exp=%h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 8'h00, 0);
            vectors++;
            if ({empty, count, newd, busy, dintx} !== {1'b1, CW'(0), 1'b0, 1'b0, 8'h00}) begin
                miscompares++;
                $display("FAIL reset_hold got=%h exp=%h", {empty, count, newd, busy, dintx},
                         {1'b1, CW'(0), 1'b0, 1'b0, 8'h00});
            end
        end
        rst = 1'b1;
        tick(0, 8'h00, 0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_byte();
        tick(1, 8'hA5, 0);
        vectors++;
        if (newd !== 1'b0 || count !== CW'(1)) begin
            miscompares++;
            $display("FAIL single_push newd=%b count=%0d exp newd=0 count=1", newd, count);
        end
        tick(0, 8'h00, 0);
        vectors++;
        if (newd !== 1'b1 || dintx !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_start newd=%b dintx=%h exp newd=1 dintx=a5", newd, dintx);
        end
        for (int i = 0; i < 10; i++) begin
            tick(0, 8'h00, 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_wait cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        tick(0, 8'h00, 1);
        for (int i = 0; i < GAP; i++) begin
            vectors++;
            if (busy !== 1'b1 || dintx !== 8'hA5) begin
                miscompares++;
                $display("FAIL single_gap busy=%b dintx=%h exp busy=1 dintx=a5", busy, dintx);
            end
            tick(0, 8'h00, 0);
        end
        vectors++;
        if (busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL single_idle got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_spurious_done();
        for (int i = 0; i < 4; i++) begin
            tick(0, 8'h00, 1);
            vectors++;
            if (newd !== 1'b0 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL spurious_done got=%h exp=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_burst();
        int   n_seen;
        int   budget;
        logic [7:0] exp_b;
        n_seen = 0;
        for (int i = 1; i <= 5; i++) begin
            tick(1, 8'(i), 0);
            if (newd === 1'b1) n_seen++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL burst_push cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        budget = 300;
        while ((m_q.size() != 0 || m_waiting || m_busy()) && budget > 0) begin
            tick(0, 8'h00, m_waiting && (cyc >= m_start + 4));
            budget--;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL burst_run cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (newd === 1'b1) begin
                n_seen++;
                exp_b = 8'(n_seen);
                vectors++;
                if (dintx !== exp_b) begin
                    miscompares++;
                    $display("FAIL burst_order got=%h exp=%h", dintx, exp_b);
                end
            end
        end
        vectors++;
        if (budget == 0 || n_seen != 5) begin
            miscompares++;
            $display("FAIL burst_count got=%0d pulses exp=5 budget_left=%0d", n_seen, budget);
        end
    endtask

    task automatic test_full();
        int budget;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            tick(1, 8'(8'h40 + i), 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_fill cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (full !== 1'b1 || count !== CW'(DEPTH) || dintx !== 8'h41) begin
            miscompares++;
            $display("FAIL full_flag full=%b count=%0d dintx=%h exp 1/%0d/41", full, count, dintx, DEPTH);
        end
        tick(1, 8'hEE, 0);
        vectors++;
        if (full !== 1'b1 || count !== CW'(DEPTH) || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL full_drop got=%h exp=%h", obs_vec(), exp_vec());
        end
`ifdef UART_TXF_OVF_EN
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL full_ovf got=%b exp=1", ovf);
        end
`endif
        budget = 400;
        while ((m_q.size() != 0 || m_waiting || m_busy()) && budget > 0) begin
            tick(0, 8'h00, m_waiting && (cyc >= m_start + 3));
            budget--;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("FAIL full_drain_timeout got=%0d exp>0", budget);
        end
    endtask

    task automatic test_reset_mid_frame();
        int pulses;
        for (int i = 0; i < 4; i++) tick(1, 8'(8'h90 + i), 0);
        for (int i = 0; i < 3; i++) tick(0, 8'h00, 0);
        vectors++;
        if (busy !== 1'b1 || count !== CW'(3)) begin
            miscompares++;
            $display("FAIL midrst_setup busy=%b count=%0d exp 1/3", busy, count);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL midrst_async got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick(0, 8'h00, 0);
        tick(0, 8'h00, 0);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 8'h00, 1);
            if (newd !== 1'b0) pulses++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL midrst_after cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL midrst_newd got=%0d pulses exp=0", pulses);
        end
    endtask

    task automatic test_random();
        bit         w;
        bit         dn;
        logic [7:0] d;
        for (int i = 0; i < 1500; i++) begin
            w  = ($urandom_range(99) < ((i / 300) % 2 == 0 ? 60 : 25));
            d  = 8'($urandom);
            dn = ($urandom_range(99) < 30);
            tick(w, d, dn);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_spurious_done();
        test_burst();
        test_full();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
